// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized line, start-edge detect, mid-bit
// sampling driven by a bit-period counter, registered data/valid/error outputs.
module uart_rx #(
   parameter int CLK_FREQUENCE = 125_000_000,
   parameter int BAUD_RATE     = 9600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BPS_CNT  = CLK_FREQUENCE / BAUD_RATE - 1;
   localparam int HALF_CNT = BPS_CNT / 2;

   // Number of bits needed to hold the value (at least one).
   function automatic int cnt_width(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if (value >= (32'sd1 <<< i)) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

   localparam int             CW       = cnt_width(BPS_CNT);
   localparam logic [CW-1:0]  BPS_MAX  = CW'(BPS_CNT);
   localparam logic [CW-1:0]  HALF_MAX = CW'(HALF_CNT);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic          sync1_r;
   logic          rx_s;
   logic          rx_d;
   state_t        state_r;
   state_t        state_nxt_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic [2:0]    bit_idx_r;
   logic [2:0]    bit_idx_nxt_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_nxt_s;
   logic [7:0]    data_nxt_s;
   logic          valid_nxt_s;
   logic          ferr_nxt_s;

   // Line synchronizer plus delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         sync1_r <= rx;
         rx_s    <= sync1_r;
         rx_d    <= rx_s;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_nxt_s   = state_r;
      count_nxt_s   = count_r;
      bit_idx_nxt_s = bit_idx_r;
      shift_nxt_s   = shift_r;
      data_nxt_s    = rx_data;
      valid_nxt_s   = 1'b0;
      ferr_nxt_s    = 1'b0;
      case (state_r)
         IDLE: begin
            count_nxt_s = CNT_ZERO;
            if (!rx_s && rx_d) begin
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (count_r == HALF_MAX) begin
               count_nxt_s   = CNT_ZERO;
               bit_idx_nxt_s = 3'd0;
               // A line that is high again at mid start bit was only a glitch.
               if (!rx_s) begin
                  state_nxt_s = DATA;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               count_nxt_s = count_r + CNT_ONE;
            end
         end
         DATA: begin
            if (count_r == BPS_MAX) begin
               count_nxt_s            = CNT_ZERO;
               shift_nxt_s[bit_idx_r] = rx_s;
               if (bit_idx_r == 3'd7) begin
                  state_nxt_s = STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               count_nxt_s = count_r + CNT_ONE;
            end
         end
         STOP: begin
            if (count_r == BPS_MAX) begin
               count_nxt_s = CNT_ZERO;
               state_nxt_s = IDLE;
               if (rx_s) begin
                  data_nxt_s  = shift_r;
                  valid_nxt_s = 1'b1;
               end else begin
                  ferr_nxt_s = 1'b1;
               end
            end else begin
               count_nxt_s = count_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            count_nxt_s = CNT_ZERO;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         count_r   <= CNT_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= 8'h00;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         count_r   <= count_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         shift_r   <= shift_nxt_s;
         rx_data   <= data_nxt_s;
         rx_valid  <= valid_nxt_s;
         frame_err <= ferr_nxt_s;
         rx_busy   <= (state_nxt_s != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: vector table, corner
// sequences (glitch, break, reset mid-frame, baud offset) and random frames.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam real BIT_NS = 160.0;
   // Posedges from the start-bit drive (1 ns after an edge) to the negedge showing the pulse.
   localparam int  LAT    = 155;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx      = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   uart_rx #(
      .CLK_FREQUENCE(1_600_000),
      .BAUD_RATE    (100_000)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx       (rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .rx_busy  (rx_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         kind;   // 0 = rx_valid, 1 = frame_err
      bit         both;
      logic [7:0] data;
      int         at;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic       exp_ferr;
      logic [7:0] exp_rx_data;
   } vec_t;

   int   cyc = 0;
   ev_t  obs_q[$];
   ev_t  exp_q[$];
   bit   busy_after_q[$];
   logic prev_valid = 1'b0;
   ev_t  mon_ev;
   int   tests = 0;
   int   fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor: every output pulse, plus rx_busy the cycle after each rx_valid.
   always @(negedge clk) begin
      if (prev_valid) busy_after_q.push_back(rx_busy);
      prev_valid <= rx_valid;
      if (rx_valid || frame_err) begin
         mon_ev.kind = !rx_valid;
         mon_ev.both = rx_valid && frame_err;
         mon_ev.data = rx_data;
         mon_ev.at   = cyc;
         obs_q.push_back(mon_ev);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns,
                             output int st);
      st = cyc;
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         #(bit_ns);
      end
      rx = stop;
      #(bit_ns);
   endtask

   task automatic push_exp(input bit kind, input logic [7:0] d, input int at);
      ev_t e;
      e.kind = kind;
      e.both = 1'b0;
      e.data = d;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic drain(input string tag, input int tol);
      ev_t e;
      ev_t o;
      bit  ba;
      repeat (20) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s missing event: got none expected kind %0d", tag, e.kind);
         end else begin
            o = obs_q.pop_front();
            chk({tag, " kind"}, o.kind, e.kind);
            chk({tag, " exclusive pulses"}, o.both, 0);
            if (e.kind == 1'b0) chk({tag, " rx_data"}, o.data, e.data);
            if (o.kind == 1'b0) begin
               ba = (busy_after_q.size() > 0) ? busy_after_q.pop_front() : 1'b1;
               chk({tag, " rx_busy after valid"}, ba, 0);
            end
            tests++;
            if (o.at < e.at - tol || o.at > e.at + tol) begin
               fails++;
               $display("FAIL %s timing: got cycle %0d expected %0d +-%0d", tag, o.at, e.at, tol);
            end
         end
      end
      chk({tag, " extra events"}, obs_q.size(), 0);
      obs_q.delete();
      busy_after_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " rx_data"}, rx_data, 8'h00);
      chk({tag, " rx_valid"}, rx_valid, 0);
      chk({tag, " frame_err"}, frame_err, 0);
      chk({tag, " rx_busy"}, rx_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[6];
      int         st;
      int         st2;
      int         busy_cnt;
      logic [7:0] model_last;
      logic [7:0] rb;
      logic       rs;
      int         gap;
      logic [7:0] b5a;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1, 8'hFF};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};

      // Reset state
      @(negedge clk);
      chk_reset_outputs("in reset");
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk_reset_outputs("after reset");

      // Vector table
      for (int i = 0; i < 6; i++) begin
         align();
         send_frame(vecs[i].data, vecs[i].stop, BIT_NS, st);
         rx = 1'b1;
         if (vecs[i].exp_valid) push_exp(1'b0, vecs[i].exp_rx_data, st + LAT);
         if (vecs[i].exp_ferr)  push_exp(1'b1, 8'h00, st + LAT);
         drain($sformatf("vec%0d", i), 0);
         chk($sformatf("vec%0d rx_data out", i), rx_data, vecs[i].exp_rx_data);
         chk($sformatf("vec%0d rx_busy idle", i), rx_busy, 0);
      end

      // Back-to-back frames without idle gap
      align();
      send_frame(8'h00, 1'b1, BIT_NS, st);
      send_frame(8'hFF, 1'b1, BIT_NS, st2);
      rx = 1'b1;
      push_exp(1'b0, 8'h00, st + LAT);
      push_exp(1'b0, 8'hFF, st2 + LAT);
      drain("back2back", 0);

      // Short low glitch on idle line
      align();
      rx = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 4) rx = 1'b1;
         busy_cnt += int'(rx_busy);
      end
      tests++;
      if (busy_cnt < 1 || busy_cnt > 12) begin
         fails++;
         $display("FAIL glitch busy cycles: got %0d expected 1..12", busy_cnt);
      end
      drain("glitch", 0);
      chk("glitch rx_data", rx_data, 8'hFF);

      // Good frame, then a framing error followed by a held-low break
      align();
      send_frame(8'hA5, 1'b1, BIT_NS, st);
      rx = 1'b1;
      push_exp(1'b0, 8'hA5, st + LAT);
      drain("pre-break", 0);
      align();
      send_frame(8'h3C, 1'b0, BIT_NS, st);
      push_exp(1'b1, 8'h00, st + LAT);
      repeat (640) @(negedge clk);
      drain("break", 0);
      chk("break rx_data kept", rx_data, 8'hA5);
      chk("break rx_busy", rx_busy, 0);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      drain("break release", 0);

      // Reset in the middle of data bit 4
      b5a = 8'h5A;
      align();
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 5; i++) begin
         rx = b5a[i];
         #(i == 4 ? BIT_NS / 2.0 : BIT_NS);
      end
      reset_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("mid-frame reset");
      rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (48) @(negedge clk);
      chk_reset_outputs("post reset");
      drain("reset abandon", 0);
      align();
      send_frame(8'h81, 1'b1, BIT_NS, st);
      rx = 1'b1;
      push_exp(1'b0, 8'h81, st + LAT);
      drain("after reset", 0);

      // +-3% baud offset
      align();
      send_frame(8'h96, 1'b1, BIT_NS * 1.03, st);
      rx = 1'b1;
      push_exp(1'b0, 8'h96, st + LAT);
      drain("baud +3%", 2);
      align();
      send_frame(8'h96, 1'b1, BIT_NS * 0.97, st);
      rx = 1'b1;
      push_exp(1'b0, 8'h96, st + LAT);
      drain("baud -3%", 2);

      // Random frames against the frame-level model
      model_last = 8'h96;
      align();
      for (int n = 0; n < 24; n++) begin
         rb  = 8'($urandom_range(0, 255));
         rs  = ($urandom_range(0, 4) != 0);
         gap = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         send_frame(rb, rs, BIT_NS, st);
         if (rs) begin
            model_last = rb;
            push_exp(1'b0, rb, st + LAT);
         end else begin
            push_exp(1'b1, 8'h00, st + LAT);
         end
         rx = 1'b1;
         #(BIT_NS * gap);
      end
      drain("random", 0);
      chk("random rx_data final", rx_data, model_last);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
